mem_access_ctrl: RTL

- Sequences one LC-3 memory transaction (read or write) between the datapath's MAR/MDR registers and the external synchronous SRAM port.
- Sits directly upstream of the MDR data register: it drives that register's Load strobe and Data_In bus when a read completes.
- Enforces a programmable minimum access time, waits on the memory ready signal, and flags a timeout if ready never arrives.

---
 rtl/lc3_pkg.sv | 11 +
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/register.sv | 18 +
 rtl/mem_access_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: memory sequencer states and default word width.
package lc3_pkg;
    localparam int N = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_RDY,
        FINISH
    } mem_state_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the datapath, the memory sequencer and the SRAM port.
interface mem_access_ctrl_if #(parameter int N = lc3_pkg::N);
    logic         req_valid;
    logic         req_write;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         req_ready;
    logic         mdr_load;
    logic [N-1:0] mdr_data;
    logic         done;
    logic         err;
    logic         mem_ce;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, mdr_load, mdr_data, done, err, mem_ce, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, mdr_load, mdr_data, done, err, mem_ce, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/register.sv
// Generic load-enabled register with synchronous active-high reset.
// Latency: q follows d one cycle after load; no backpressure.
module register #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one LC-3 SRAM read/write from MAR/MDR, feeding MDR Load/Data_In on read completion.
// Latency: Done at WAIT_CYCLES+2 after acceptance with ready already high; aborts after TIMEOUT.
// Backpressure: req_ready only in IDLE; requests while busy are dropped, not queued.
module mem_access_ctrl #(
    parameter int N           = lc3_pkg::N,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_ctrl_if.slave bus
);
    import lc3_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t    state, next_state;
    logic [CW-1:0] cnt;
    logic          write_q;
    logic          accept, rdy_hit, tmo_hit;
    logic          req_ready_d, ce_d, we_d, done_d, load_d;

    assign accept  = (state == IDLE) && bus.req_valid;
    assign rdy_hit = (state == WAIT_RDY) && bus.mem_ready;
    // ready wins over a timeout landing on the same cycle
    assign tmo_hit = (state == WAIT_RDY) && !bus.mem_ready && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.req_valid) next_state = ACCESS;
            ACCESS:   if (cnt == CW'(WAIT_CYCLES - 1)) next_state = WAIT_RDY;
            WAIT_RDY: if (rdy_hit || tmo_hit) next_state = FINISH;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // next-cycle values of the registered outputs
    always_comb begin
        req_ready_d = (next_state == IDLE);
        ce_d        = (next_state == ACCESS) || (next_state == WAIT_RDY);
        we_d        = ce_d && (accept ? bus.req_write : write_q);
        done_d      = (next_state == FINISH);
        load_d      = rdy_hit && !write_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            write_q       <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.mem_ce    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.done      <= 1'b0;
            bus.mdr_load  <= 1'b0;
            bus.mdr_data  <= '0;
            bus.err       <= 1'b0;
        end else begin
            state         <= next_state;
            bus.req_ready <= req_ready_d;
            bus.mem_ce    <= ce_d;
            bus.mem_we    <= we_d;
            bus.done      <= done_d;
            bus.mdr_load  <= load_d;
            if (accept) begin
                write_q <= bus.req_write;
                bus.err <= 1'b0;
            end else if (tmo_hit) begin
                bus.err <= 1'b1;
            end
            if (load_d)
                bus.mdr_data <= bus.mem_rdata;
            if (accept)
                cnt <= '0;
            else if (((state == ACCESS) || (state == WAIT_RDY)) && (cnt != CW'(TIMEOUT)))
                cnt <= cnt + 1'b1;
        end
    end

    register #(.W(N)) u_addr_reg (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .d     (bus.req_addr),
        .q     (bus.mem_addr)
    );

    register #(.W(N)) u_wdata_reg (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .d     (bus.req_wdata),
        .q     (bus.mem_wdata)
    );
endmodule
